bus_bridge_xlate_framer: RTL and testbench
==========================================

// Module: bus_bridge_xlate_framer
// PURPOSE
//  Next-generation request front-end for the bus bridge target side. Decodes a bus request against NUM_WIN remote address windows.
//  Translates hits to the bus-B address and queues them in a FIFO. Serialises each entry as a byte frame on a valid/ready
//  stream feeding the UART transmitter. Misses are consumed and flagged.
// PARAMETERS
//  BRIDGE_BASE_ADDR  16'h8000  local base of window 0; windows are contiguous upward
//  NUM_WIN           3         number of windows, legal 1..4
//  WIN_SIZE_LOG2     12        log2 of each window size in bytes (all windows equal)
//  REMOTE_BASES      {16'h8000,16'h4000,16'h0000}  packed NUM_WIN*16 bits; slice w = bus-B base of window w
//  FIFO_DEPTH        4         request FIFO entries, power of two >= 2
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    asynchronous active-low reset
//  req_addr     in   16   local request address
//  req_data     in   8    write data; ignored for reads
//  req_rw       in   1    1 = write, 0 = read
//  req_valid    in   1    request present
//  req_ready    out  1    request accepted this cycle when req_valid && req_ready
//  req_miss     out  1    one-cycle pulse: accepted request hit no window
//  tx_byte      out  8    frame byte to UART TX
//  tx_valid     out  1    tx_byte valid
//  tx_ready     in   1    UART TX takes byte when tx_valid && tx_ready
//  fifo_level   out  $clog2(FIFO_DEPTH)+1   queued entries, excluding the frame in flight
//  frame_count  out  16   frames fully sent, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset, asynchronous: FIFO emptied, FSM=IDLE, frame register cleared. Outputs: tx_valid=0, tx_byte=0, req_miss=0,
//    fifo_level=0, frame_count=0, req_ready=1.
//  - Decode: off = req_addr - BRIDGE_BASE_ADDR (16-bit); win = off >> WIN_SIZE_LOG2.
//    Hit iff req_addr >= BRIDGE_BASE_ADDR and win < NUM_WIN.
//  - Translate: remote = REMOTE_BASES[w] + off[WIN_SIZE_LOG2-1:0], modulo 2^16.
//  - req_ready = !fifo_full. No push bypass when full, even if the FIFO pops in the same cycle.
//  - Accepted hit: push {rw, win[1:0], remote, data} into the FIFO. Reads store data=8'h00.
//  - Accepted miss: no push; req_miss=1 on the next cycle for exactly one cycle.
//  - Simultaneous push and pop on a non-full FIFO: level unchanged, order preserved.
//  - Frame bytes, in order:
//      HDR = {4'hA, rw, 1'b0, win[1:0]}
//      AHI = remote[15:8]
//      ALO = remote[7:0]
//      DAT = data
//      CHK (optional, see CONFIGURATION)
//  - FSM: IDLE, HDR, AHI, ALO, DAT, CHK.
//    IDLE with FIFO non-empty: pop into frame register -> HDR.
//    Each state advances on tx_valid && tx_ready.
//    Last byte handshake: frame_count += 1; then -> HDR with a pop if FIFO non-empty (no bubble), else -> IDLE.
//  - tx_valid=1 in every state except IDLE. tx_byte is registered and held stable while tx_valid && !tx_ready.
//  - Latency: a request accepted at edge N into an empty, idle block gives tx_valid=1 with HDR after edge N+2.
//  - Reset mid-frame: the partial frame and all queued entries are discarded; nothing is resumed.
// CONFIGURATION
//  BUS_BRIDGE_CHECKSUM_EN defined:
//    - frame is 5 bytes; CHK = HDR ^ AHI ^ ALO ^ DAT; the frame ends after CHK.
//  BUS_BRIDGE_CHECKSUM_EN undefined:
//    - frame is 4 bytes; the frame ends after DAT; CHK state unreachable; HDR bit 2 stays 0.
// TESTING
//  Checksum on for all cases.
//  - Write 0x9234, data 0x5A, tx_ready=1 -> bytes A9,42,34,5A,85; frame_count=1; req_miss=0.
//  - Read 0x8010 -> bytes A0,00,10,00,B0.
//  - Reads 0x7FFF and 0xB000 (window index 3 >= NUM_WIN) -> each pulses req_miss once; no tx_valid; fifo_level stays 0.
//  - Hold tx_ready=0, offer 6 back-to-back writes:
//      5 accepted (1 in frame register + 4 queued), fifo_level=4, req_ready=0 on the 6th;
//      tx_byte holds A8-class HDR;
//      release tx_ready -> 25 bytes contiguous, no idle cycle between frames.
//  - Assert rst_n=0 after AHI of the first of 3 queued frames -> tx_valid=0 immediately, fifo_level=0, frame_count=0;
//    no bytes after release.
//  - Window edge 0xAFFF, write 0x11 -> remote 0x8FFF: bytes AA,8F,FF,11,CB.

Source files
------------

// File: rtl/bus_bridge_xlate_framer.sv
// Bus bridge request front-end: window decode, address translation, request FIFO and UART byte framer.
// Optional checksum byte: define BUS_BRIDGE_CHECKSUM_EN.
module bus_bridge_xlate_framer #(
  parameter logic [15:0]           BRIDGE_BASE_ADDR = 16'h8000,
  parameter int                    NUM_WIN          = 3,
  parameter int                    WIN_SIZE_LOG2    = 12,
  parameter logic [NUM_WIN*16-1:0] REMOTE_BASES     = {16'h8000, 16'h4000, 16'h0000},
  parameter int                    FIFO_DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  req_addr,
  input  logic [7:0]                   req_data,
  input  logic                         req_rw,
  input  logic                         req_valid,
  output logic                         req_ready,
  output logic                         req_miss,
  output logic [7:0]                   tx_byte,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 27;
  localparam logic [AW:0]  FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]  OFF_MASK = 16'((32'd1 << WIN_SIZE_LOG2) - 32'd1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_AHI  = 3'd2;
  localparam logic [2:0] ST_ALO  = 3'd3;
  localparam logic [2:0] ST_DAT  = 3'd4;
  localparam logic [2:0] ST_CHK  = 3'd5;
`ifdef BUS_BRIDGE_CHECKSUM_EN
  localparam logic [2:0] LAST_ST = ST_CHK;
`else
  localparam logic [2:0] LAST_ST = ST_DAT;
`endif

  logic [15:0]   off;
  logic [15:0]   win_idx;
  logic [15:0]   remote_base;
  logic [15:0]   remote;
  logic          hit;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;

  logic [2:0]    state;
  logic          level_seen;
  logic          tx_hs;
  logic          last_hs;
  logic [15:0]   fr_remote;
  logic [7:0]    fr_data;
`ifdef BUS_BRIDGE_CHECKSUM_EN
  logic [7:0]    fr_hdr;
  logic [7:0]    chk_byte;
`endif

  always_comb begin
    off         = req_addr - BRIDGE_BASE_ADDR;
    win_idx     = off >> WIN_SIZE_LOG2;
    hit         = (req_addr >= BRIDGE_BASE_ADDR) && (win_idx < 16'(NUM_WIN));
    remote_base = '0;
    for (int w = 0; w < NUM_WIN; w++)
      if (win_idx == 16'(w)) remote_base = REMOTE_BASES[w*16 +: 16];
    remote      = remote_base + (off & OFF_MASK);
  end

  assign fifo_full  = (count == FULL_LVL);
  assign fifo_empty = (count == '0);
  assign req_ready  = !fifo_full;
  assign fifo_level = count;
  assign push       = req_valid && req_ready && hit;
  assign push_entry = {req_rw, win_idx[1:0], remote, (req_rw ? req_data : 8'h00)};
  assign head       = mem[rd_ptr];

  assign tx_valid = (state != ST_IDLE);
  assign tx_hs    = tx_valid && tx_ready;
  assign last_hs  = tx_hs && (state == LAST_ST);
  // An idle launch waits for the occupancy seen on the previous edge; chained frames pop at once.
  assign pop      = !fifo_empty && (((state == ST_IDLE) && level_seen) || last_hs);

`ifdef BUS_BRIDGE_CHECKSUM_EN
  assign chk_byte = fr_hdr ^ fr_remote[15:8] ^ fr_remote[7:0] ^ fr_data;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_miss <= 1'b0;
    end else begin
      req_miss <= req_valid && req_ready && !hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      level_seen  <= 1'b0;
      tx_byte     <= 8'h00;
      fr_remote   <= 16'h0000;
      fr_data     <= 8'h00;
      frame_count <= 16'h0000;
`ifdef BUS_BRIDGE_CHECKSUM_EN
      fr_hdr      <= 8'h00;
`endif
    end else begin
      level_seen <= !fifo_empty;
      if (last_hs) frame_count <= frame_count + 1'b1;
      if (pop) begin
        state     <= ST_HDR;
        tx_byte   <= {4'hA, head[26], 1'b0, head[25:24]};
        fr_remote <= head[23:8];
        fr_data   <= head[7:0];
`ifdef BUS_BRIDGE_CHECKSUM_EN
        fr_hdr    <= {4'hA, head[26], 1'b0, head[25:24]};
`endif
      end else if (last_hs) begin
        state <= ST_IDLE;
      end else if (tx_hs) begin
        case (state)
          ST_HDR: begin
            state   <= ST_AHI;
            tx_byte <= fr_remote[15:8];
          end
          ST_AHI: begin
            state   <= ST_ALO;
            tx_byte <= fr_remote[7:0];
          end
          ST_ALO: begin
            state   <= ST_DAT;
            tx_byte <= fr_data;
          end
          ST_DAT: begin
`ifdef BUS_BRIDGE_CHECKSUM_EN
            state   <= ST_CHK;
            tx_byte <= chk_byte;
`else
            state   <= ST_IDLE;
`endif
          end
          ST_CHK:  state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_bridge_xlate_framer.sv
// Self-checking bench for bus_bridge_xlate_framer: directed vector table, back-pressure and reset
// sequences, then randomized traffic against a queue-based frame model.
module tb_bus_bridge_xlate_framer;

`ifdef BUS_BRIDGE_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic        req_rw = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_miss;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [2:0]  fifo_level;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  bus_bridge_xlate_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_rw      (req_rw),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_miss    (req_miss),
    .tx_byte     (tx_byte),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .fifo_level  (fifo_level),
    .frame_count (frame_count)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic        hit;
    logic [39:0] bytes;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic        miss_pend = 1'b0;
  int          miss_seen = 0;
  int          model_frames = 0;
  int          byte_idx = 0;
  logic        rand_rdy = 1'b0;
  int          remote_tbl [3] = '{32'h0000, 32'h4000, 32'h8000};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame built from the address map with plain arithmetic.
  function automatic logic model_frame(input logic [15:0] a, input logic [7:0] d, input logic w,
                                       output logic [39:0] bytes);
    int off, win, remote;
    logic [7:0] hdr, hi, lo, dat;
    bytes = '0;
    if (int'(a) < 32'h8000) return 1'b0;
    off = int'(a) - 32'h8000;
    win = off / 4096;
    if (win >= 3) return 1'b0;
    remote = (remote_tbl[win] + off % 4096) % 65536;
    hdr = 8'hA0 | (w ? 8'h08 : 8'h00) | 8'(win);
    hi  = 8'(remote / 256);
    lo  = 8'(remote % 256);
    dat = w ? d : 8'h00;
    bytes = {hdr, hi, lo, dat, hdr ^ hi ^ lo ^ dat};
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [39:0] mb;
    logic        mh;
    logic [8:0]  eb;
    if (!rst_n) begin
      exp_q.delete();
      miss_pend = 1'b0;
      model_frames = 0;
      byte_idx = 0;
    end else begin
      checkOutput("req_miss", req_miss, miss_pend);
      if (req_miss) miss_seen++;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_byte);
        eb = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        checkOutput("tx_byte_stream", {1'b0, tx_byte}, eb);
        checkOutput("frame_count_run", frame_count, model_frames & 32'hFFFF);
        byte_idx++;
        if (byte_idx == FRAME_LEN) begin
          byte_idx = 0;
          model_frames++;
        end
      end
      miss_pend = 1'b0;
      if (req_valid && req_ready) begin
        mh = model_frame(req_addr, req_data, req_rw, mb);
        if (mh) begin
          for (int k = 0; k < FRAME_LEN; k++) exp_q.push_back(mb[39-8*k -: 8]);
        end else begin
          miss_pend = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic w);
    int guard;
    guard = 0;
    req_addr = a;
    req_data = d;
    req_rw = w;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("req_accept_timeout", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [7];
    int   hits_done;
    int   acc;
    int   vcnt;
    int   g;
    int   m0;
    logic [15:0] ra;

    vecs[0] = '{16'h9234, 8'h5A, 1'b1, 1'b1, 40'hA942345A85};
    vecs[1] = '{16'h8010, 8'h77, 1'b0, 1'b1, 40'hA0001000B0};
    vecs[2] = '{16'h7FFF, 8'h00, 1'b0, 1'b0, 40'h0};
    vecs[3] = '{16'hB000, 8'h00, 1'b0, 1'b0, 40'h0};
    vecs[4] = '{16'hAFFF, 8'h11, 1'b1, 1'b1, 40'hAA8FFF11CB};
    vecs[5] = '{16'hA000, 8'h3C, 1'b0, 1'b1, 40'hA280000022};
    vecs[6] = '{16'h8FFF, 8'hFF, 1'b1, 1'b1, 40'hA80FFFFFA7};
    hits_done = 0;

    $display("[TB] reset checks");
    repeat (2) @(negedge clk);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_byte", tx_byte, 0);
    checkOutput("rst_req_miss", req_miss, 0);
    checkOutput("rst_fifo_level", fifo_level, 0);
    checkOutput("rst_frame_count", frame_count, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 7; i++) begin
      got_q.delete();
      m0 = miss_seen;
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].rw);
      if (vecs[i].hit) begin
        @(negedge clk); checkOutput($sformatf("vec%0d_lat_edge1", i), tx_valid, 0);
        @(negedge clk); checkOutput($sformatf("vec%0d_lat_edge2", i), tx_valid, 0);
        @(negedge clk); checkOutput($sformatf("vec%0d_lat_valid", i), tx_valid, 1);
        checkOutput($sformatf("vec%0d_lat_hdr", i), tx_byte, vecs[i].bytes[39:32]);
        g = 0;
        while (got_q.size() < FRAME_LEN && g < 50) begin
          @(negedge clk);
          g++;
        end
        checkOutput($sformatf("vec%0d_nbytes", i), got_q.size(), FRAME_LEN);
        for (int k = 0; k < FRAME_LEN && k < got_q.size(); k++)
          checkOutput($sformatf("vec%0d_byte%0d", i, k), got_q[k], vecs[i].bytes[39-8*k -: 8]);
        hits_done++;
        repeat (2) @(negedge clk);
        checkOutput($sformatf("vec%0d_frame_count", i), frame_count, hits_done);
        checkOutput($sformatf("vec%0d_idle", i), tx_valid, 0);
        checkOutput($sformatf("vec%0d_no_miss", i), miss_seen - m0, 0);
      end else begin
        repeat (6) @(negedge clk);
        checkOutput($sformatf("vec%0d_miss_no_tx", i), got_q.size(), 0);
        checkOutput($sformatf("vec%0d_miss_pulses", i), miss_seen - m0, 1);
        checkOutput($sformatf("vec%0d_miss_level", i), fifo_level, 0);
      end
      @(posedge clk); #1;
    end

    $display("[TB] back-pressure sequence");
    tx_ready = 1'b0;
    got_q.delete();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 16'h8100 + 16'(i);
      req_data = 8'h10 + 8'(i);
      req_rw = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      if (i == 5) begin
        checkOutput("bp_ready_6th", req_ready, 0);
        checkOutput("bp_level_full", fifo_level, 4);
      end
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checkOutput("bp_accepted", acc, 5);
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", tx_valid, 1);
      checkOutput("bp_hold_hdr", tx_byte, 8'hA8);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    vcnt = 0;
    repeat (5 * FRAME_LEN) begin
      @(negedge clk);
      if (tx_valid) vcnt++;
    end
    checkOutput("bp_contiguous", vcnt, 5 * FRAME_LEN);
    @(negedge clk);
    checkOutput("bp_idle_after", tx_valid, 0);
    checkOutput("bp_nbytes", got_q.size(), 5 * FRAME_LEN);
    @(posedge clk); #1;

    $display("[TB] reset mid-frame sequence");
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(16'h8200 + 16'(i), 8'h20 + 8'(i), 1'b1);
    g = 0;
    while (!tx_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    checkOutput("mid_launch", tx_valid, 1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checkOutput("mid_level_before", fifo_level, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx_valid", tx_valid, 0);
    checkOutput("mid_rst_level", fifo_level, 0);
    checkOutput("mid_rst_frame_count", frame_count, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) vcnt++;
    end
    checkOutput("mid_no_resume", vcnt, 0);
    @(posedge clk); #1;

    $display("[TB] randomized traffic");
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 4) == 0) ra = 16'($urandom_range(0, 16'hFFFF));
      else ra = 16'($urandom_range(16'h7800, 16'hC100));
      applyStimulus(ra, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    rand_rdy = 1'b0;
    @(posedge clk); #3;
    tx_ready = 1'b1;
    g = 0;
    @(negedge clk);
    while ((tx_valid || fifo_level != 0) && g < 600) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    checkOutput("rand_drained_idle", tx_valid, 0);
    checkOutput("rand_model_empty", exp_q.size(), 0);
    checkOutput("rand_frame_count", frame_count, model_frames & 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

endmodule
